// File: rtl/sme_table_loader.sv
// sme_table_loader: write-side master for the shift-or match tables.
// Executes host CLEAR (fill every entry with CLEAR_VAL) and LOAD (stream a run
// of entries into consecutive addresses, wrapping modulo DEPTH) commands.
// Writes are only issued while the engine reports idle, because write port A
// shares its address with the byte lookup.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   cmd_clear/cmd_load  one-cycle command pulses
//   cmd_base/cmd_len    LOAD start address and entry count (0..DEPTH)
//   s_data/s_valid      entry stream in, accepted when s_valid & s_ready
//   s_ready             entry stream ready
//   filter_idle         engine not matching; writes permitted
//   wr_data/wr_addr     table write data/address, qualified by wr_en
//   wr_en               table write strobe (one cycle after acceptance)
//   busy                command in progress
//   done                one-cycle pulse on command completion
//   err                 one-cycle pulse, one cycle after a rejected command
module sme_table_loader #(
   parameter int unsigned       DWIDTH    = 64,
   parameter int unsigned       AWIDTH    = 13,
   parameter int unsigned       DEPTH     = 8192,
   parameter logic [DWIDTH-1:0] CLEAR_VAL = {DWIDTH{1'b1}}
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cmd_clear,
   input  logic              cmd_load,
   input  logic [AWIDTH-1:0] cmd_base,
   input  logic [AWIDTH:0]   cmd_len,
   input  logic [DWIDTH-1:0] s_data,
   input  logic              s_valid,
   output logic              s_ready,
   input  logic              filter_idle,
   output logic [DWIDTH-1:0] wr_data,
   output logic [AWIDTH-1:0] wr_addr,
   output logic              wr_en,
   output logic              busy,
   output logic              done,
   output logic              err
);

   localparam logic [AWIDTH:0]   DepthCnt = (AWIDTH+1)'(DEPTH);
   localparam logic [AWIDTH-1:0] LastAddr = AWIDTH'(DEPTH - 1);

   typedef enum logic [1:0] {StIdle, StClear, StLoad, StFin} state_e;

   state_e              state_q, state_d;
   logic [AWIDTH-1:0]   addr_q, addr_d;
   logic [AWIDTH:0]     rem_q, rem_d;
   logic                wr_en_q, wr_en_d;
   logic [AWIDTH-1:0]   wr_addr_q, wr_addr_d;
   logic [DWIDTH-1:0]   wr_data_q, wr_data_d;
   logic                err_q, err_d;
   logic                any_cmd;
   logic [AWIDTH-1:0]   addr_inc;

   assign any_cmd  = cmd_clear | cmd_load;
   // Explicit wrap so a non-power-of-two DEPTH still wraps correctly.
   assign addr_inc = (addr_q == LastAddr) ? '0 : addr_q + AWIDTH'(1);

   // rem_q is never 0 while in StLoad; the term keeps the handshake safe anyway.
   assign s_ready = (state_q == StLoad) && filter_idle && (rem_q != '0);

   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      rem_d     = rem_q;
      wr_en_d   = 1'b0;
      wr_addr_d = wr_addr_q;
      wr_data_d = wr_data_q;
      err_d     = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (cmd_clear) begin
               // CLEAR has priority; a coincident LOAD is dropped and flagged.
               state_d = StClear;
               addr_d  = '0;
               rem_d   = DepthCnt;
               err_d   = cmd_load;
            end else if (cmd_load) begin
               if (cmd_len > DepthCnt) begin
                  err_d = 1'b1;
               end else if (cmd_len == '0) begin
                  state_d = StFin;
               end else begin
                  state_d = StLoad;
                  addr_d  = cmd_base;
                  rem_d   = cmd_len;
               end
            end
         end

         StClear: begin
            err_d = any_cmd;
            if (filter_idle) begin
               wr_en_d   = 1'b1;
               wr_addr_d = addr_q;
               wr_data_d = CLEAR_VAL;
               addr_d    = addr_inc;
               rem_d     = rem_q - (AWIDTH+1)'(1);
               if (rem_q == (AWIDTH+1)'(1)) state_d = StFin;
            end
         end

         StLoad: begin
            err_d = any_cmd;
            if (s_valid && s_ready) begin
               wr_en_d   = 1'b1;
               wr_addr_d = addr_q;
               wr_data_d = s_data;
               addr_d    = addr_inc;
               rem_d     = rem_q - (AWIDTH+1)'(1);
               if (rem_q == (AWIDTH+1)'(1)) state_d = StFin;
            end
         end

         StFin: begin
            // The last write is on the port this cycle; it retires here.
            err_d   = any_cmd;
            state_d = StIdle;
         end

         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= StIdle;
         addr_q    <= '0;
         rem_q     <= '0;
         wr_en_q   <= 1'b0;
         wr_addr_q <= '0;
         wr_data_q <= '0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         rem_q     <= rem_d;
         wr_en_q   <= wr_en_d;
         wr_addr_q <= wr_addr_d;
         wr_data_q <= wr_data_d;
         err_q     <= err_d;
      end
   end

   assign wr_en   = wr_en_q;
   assign wr_addr = wr_addr_q;
   assign wr_data = wr_data_q;
   assign err     = err_q;
   assign busy    = (state_q != StIdle);
   assign done    = (state_q == StFin);

endmodule
